keypad_scan: RTL and testbench

- Parameterised matrix keypad scanner for the ghostchip console; next generation of the fixed 4x4 keypad block.
- Drives rows one at a time and samples columns through a synchroniser.
- Debounces every key independently and exports a live key bitmap plus a FIFO of press/release events for the CPU (Fx0A wait-for-key).
- Sits between the keypad pins and the cpu.

---
 rtl/keypad_scan.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: row-at-a-time drive, synchronised column sampling,
// per-key debounce, and a press/release event FIFO for the CPU.
module keypad_scan #(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned SCAN_DIV   = 1024,
   parameter int unsigned DEBOUNCE   = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [ROWS-1:0]              row_out,
   input  logic [COLS-1:0]              col_in,
   output logic [ROWS*COLS-1:0]         matrix,
   output logic                         any_key,
   output logic                         key_valid,
   output logic [$clog2(ROWS*COLS)-1:0] key_code,
   output logic                         key_press,
   input  logic                         key_ready,
   output logic                         overflow,
   input  logic                         overflow_clr
);

   localparam int unsigned NKEYS = ROWS * COLS;
   localparam int unsigned KW    = $clog2(NKEYS);
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BW    = $clog2(DEBOUNCE + 1);
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNW   = PW + 1;
   localparam int unsigned EW    = KW + 1;

   typedef enum logic [0:0] {SETTLE, EVAL} state_e;

   state_e              state_q, state_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [RW-1:0]       row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic [COLS-1:0]     samp_q, samp_d;
   logic [COLS-1:0]     sync1_q, sync2_q;
   logic [NKEYS-1:0]    stable_q, stable_d;
   logic [BW-1:0]       dbc_q [NKEYS];
   logic [BW-1:0]       dbc_d [NKEYS];
   logic [ROWS-1:0]     row_out_q, row_out_d;
   logic                any_key_q, any_key_d;

   logic [EW-1:0]       mem_q [FIFO_DEPTH];
   logic [EW-1:0]       mem_d [FIFO_DEPTH];
   logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
   logic [CNW-1:0]      cnt_q, cnt_d;
   logic                key_valid_q, key_valid_d;
   logic [EW-1:0]       head_q, head_d;
   logic                overflow_q, overflow_d;

   logic [COLS-1:0]     col_norm_c;
   logic [KW-1:0]       key_idx_c;
   logic                push_c;
   logic [EW-1:0]       ev_c;

   assign col_norm_c = ACTIVE_LOW ? ~sync2_q : sync2_q;
   assign key_idx_c  = KW'(32'(row_q) * COLS + 32'(col_q));

   // Scan sequencer and per-key debounce
   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      row_d     = row_q;
      col_d     = col_q;
      samp_d    = samp_q;
      stable_d  = stable_q;
      dbc_d     = dbc_q;
      push_c    = 1'b0;
      ev_c      = {key_idx_c, ~stable_q[key_idx_c]};
      case (state_q)
         SETTLE: begin
            if (dwell_q == DW'(SCAN_DIV - 1)) begin
               samp_d  = col_norm_c;
               dwell_d = '0;
               col_d   = '0;
               state_d = EVAL;
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         EVAL: begin
            if (samp_q[col_q] == stable_q[key_idx_c]) begin
               dbc_d[key_idx_c] = '0;
            end else if (dbc_q[key_idx_c] == BW'(DEBOUNCE - 1)) begin
               stable_d[key_idx_c] = ~stable_q[key_idx_c];
               dbc_d[key_idx_c]    = '0;
               push_c              = 1'b1;
            end else begin
               dbc_d[key_idx_c] = dbc_q[key_idx_c] + BW'(1);
            end
            if (col_q == CW'(COLS - 1)) begin
               col_d   = '0;
               row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
               dwell_d = '0;
               state_d = SETTLE;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         default: state_d = SETTLE;
      endcase
      // Row drive tracks the next row index so it switches with the state
      row_out_d = ACTIVE_LOW ? ~(ROWS'(1) << row_d) : (ROWS'(1) << row_d);
      any_key_d = |stable_d;
   end

   // Event FIFO with a registered head
   always_comb begin
      logic pop_c;
      logic full_c;
      logic push_ok_c;
      mem_d       = mem_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      overflow_d  = overflow_q;
      head_d      = head_q;
      pop_c       = key_valid_q && key_ready;
      full_c      = (cnt_q == CNW'(FIFO_DEPTH));
      push_ok_c   = push_c && (!full_c || pop_c);
      if (pop_c) begin
         rd_d = rd_q + PW'(1);
      end
      if (push_ok_c) begin
         mem_d[wr_q] = ev_c;
         wr_d        = wr_q + PW'(1);
      end
      cnt_d = cnt_q + CNW'(push_ok_c) - CNW'(pop_c);
      if (overflow_clr) begin
         overflow_d = 1'b0;
      end
      if (push_c && !push_ok_c) begin
         overflow_d = 1'b1;
      end
      key_valid_d = (cnt_d != '0);
      if (key_valid_d) begin
         head_d = mem_d[rd_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SETTLE;
         dwell_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         samp_q      <= '0;
         sync1_q     <= {COLS{ACTIVE_LOW}};
         sync2_q     <= {COLS{ACTIVE_LOW}};
         stable_q    <= '0;
         dbc_q       <= '{default: '0};
         row_out_q   <= {ROWS{ACTIVE_LOW}};
         any_key_q   <= 1'b0;
         mem_q       <= '{default: '0};
         rd_q        <= '0;
         wr_q        <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         head_q      <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dwell_q     <= dwell_d;
         row_q       <= row_d;
         col_q       <= col_d;
         samp_q      <= samp_d;
         sync1_q     <= col_in;
         sync2_q     <= sync1_q;
         stable_q    <= stable_d;
         dbc_q       <= dbc_d;
         row_out_q   <= row_out_d;
         any_key_q   <= any_key_d;
         mem_q       <= mem_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         head_q      <= head_d;
         overflow_q  <= overflow_d;
      end
   end

   assign row_out   = row_out_q;
   assign matrix    = stable_q;
   assign any_key   = any_key_q;
   assign key_valid = key_valid_q;
   assign key_code  = head_q[EW-1:1];
   assign key_press = head_q[0];
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: 4x4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4, active-low.
module tb_keypad_scan;

   localparam int unsigned ROWS = 4;
   localparam int unsigned COLS = 4;
   localparam logic [ROWS-1:0] ROW0_ON = 4'b1110;
   localparam logic [ROWS-1:0] ROW_OFF = 4'b1111;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [ROWS-1:0]      row_out;
   logic [COLS-1:0]      col_in;
   logic [ROWS*COLS-1:0] matrix;
   logic                 any_key;
   logic                 key_valid;
   logic [3:0]           key_code;
   logic                 key_press;
   logic                 key_ready = 1'b0;
   logic                 overflow;
   logic                 overflow_clr = 1'b0;

   logic [15:0]          keys = '0;
   int                   n_checks = 0;
   int                   n_fail = 0;
   int                   cyc;

   keypad_scan #(
      .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(3), .FIFO_DEPTH(4), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .row_out(row_out), .col_in(col_in),
      .matrix(matrix), .any_key(any_key), .key_valid(key_valid),
      .key_code(key_code), .key_press(key_press), .key_ready(key_ready),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   always #5 clk = ~clk;

   // Switch matrix: a pressed key pulls its column low while its row is driven low
   always_comb begin
      col_in = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge just after row 0 becomes active (start of a frame)
   task automatic frame_sync(output int cycles);
      logic [ROWS-1:0] prev;
      bit hit;
      prev = row_out;
      hit = 1'b0;
      cycles = 0;
      while (!hit && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (row_out == ROW0_ON && prev != ROW0_ON) hit = 1'b1;
         prev = row_out;
      end
      check_eq("frame_sync_seen", 32'(hit), 32'd1);
   endtask

   task automatic frames(input int n);
      int c;
      for (int i = 0; i < n; i++) frame_sync(c);
   endtask

   task automatic expect_ev(input string tag, input int code, input bit press);
      check_eq({tag, "_valid"}, 32'(key_valid), 32'd1);
      check_eq({tag, "_code"},  32'(key_code),  32'(code));
      check_eq({tag, "_press"}, 32'(key_press), 32'(press));
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_row_out", 32'(row_out), 32'(ROW_OFF));
      check_eq("rst_matrix", 32'(matrix), 32'd0);
      check_eq("rst_valid", 32'(key_valid), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_any_key", 32'(any_key), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("rst_row_hold", 32'(row_out), 32'(ROW_OFF));
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("first_edge_row0", 32'(row_out), 32'(ROW0_ON));

      // Frame period
      frame_sync(cyc);
      frame_sync(cyc);
      check_eq("frame_period", 32'(cyc), 32'd48);

      // Single press / release of key 5
      keys = 16'h0020;
      frames(2);
      check_eq("k5_2samples_matrix", 32'(matrix), 32'd0);
      check_eq("k5_2samples_valid", 32'(key_valid), 32'd0);
      frames(1);
      check_eq("k5_press_matrix", 32'(matrix), 32'h0020);
      check_eq("k5_any_key", 32'(any_key), 32'd1);
      expect_ev("k5_press", 5, 1'b1);
      check_eq("k5_empty", 32'(key_valid), 32'd0);
      keys = 16'h0000;
      frames(2);
      check_eq("k5_rel_2samples", 32'(matrix), 32'h0020);
      frames(1);
      expect_ev("k5_rel", 5, 1'b0);
      check_eq("k5_rel_matrix", 32'(matrix), 32'd0);
      check_eq("k5_rel_any_key", 32'(any_key), 32'd0);

      // Bounce rejection on key 10
      keys = 16'h0400;
      frames(2);
      keys = 16'h0000;
      frames(3);
      check_eq("bounce_matrix", 32'(matrix), 32'd0);
      check_eq("bounce_valid", 32'(key_valid), 32'd0);
      keys = 16'h0400;
      frames(3);
      check_eq("k10_matrix", 32'(matrix), 32'h0400);
      expect_ev("k10_press", 10, 1'b1);
      keys = 16'h0000;
      frames(3);
      expect_ev("k10_rel", 10, 1'b0);

      // Same-row multi-key: 12, 13, 14
      keys = 16'h7000;
      frames(3);
      check_eq("row3_matrix", 32'(matrix), 32'h7000);
      expect_ev("row3_a", 12, 1'b1);
      expect_ev("row3_b", 13, 1'b1);
      expect_ev("row3_c", 14, 1'b1);
      check_eq("row3_empty", 32'(key_valid), 32'd0);
      keys = 16'h0000;
      frames(3);
      expect_ev("row3_rel_a", 12, 1'b0);
      expect_ev("row3_rel_b", 13, 1'b0);
      expect_ev("row3_rel_c", 14, 1'b0);

      // Overflow: five presses into a four-deep FIFO
      keys = 16'h8252;
      frames(3);
      check_eq("ovf_flag", 32'(overflow), 32'd1);
      check_eq("ovf_matrix", 32'(matrix), 32'h8252);
      repeat (5) @(negedge clk);
      check_eq("ovf_hold_code", 32'(key_code), 32'd1);
      expect_ev("ovf_a", 1, 1'b1);
      expect_ev("ovf_b", 4, 1'b1);
      expect_ev("ovf_c", 6, 1'b1);
      expect_ev("ovf_d", 9, 1'b1);
      check_eq("ovf_drained", 32'(key_valid), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("ovf_sticky", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      check_eq("ovf_cleared", 32'(overflow), 32'd0);

      // Push and pop together while full: key 15 release lands at the frame boundary
      frame_sync(cyc);
      keys = 16'h0000;
      frames(2);
      repeat (47) @(negedge clk);
      check_eq("full_head", 32'(key_code), 32'd1);
      check_eq("full_matrix", 32'(matrix), 32'h8000);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
      check_eq("full_no_drop", 32'(overflow), 32'd0);
      check_eq("full_matrix_clear", 32'(matrix), 32'd0);
      expect_ev("full_b", 4, 1'b0);
      expect_ev("full_c", 6, 1'b0);
      expect_ev("full_d", 9, 1'b0);
      expect_ev("full_e", 15, 1'b0);
      check_eq("full_empty", 32'(key_valid), 32'd0);

      // Reset mid-EVAL with two events queued and key 7 partly debounced
      frame_sync(cyc);
      keys = 16'h0005;
      frames(3);
      keys = 16'h0085;
      frames(2);
      check_eq("pre_rst_matrix", 32'(matrix), 32'h0005);
      check_eq("pre_rst_valid", 32'(key_valid), 32'd1);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_row_out", 32'(row_out), 32'(ROW_OFF));
      check_eq("mid_rst_matrix", 32'(matrix), 32'd0);
      check_eq("mid_rst_valid", 32'(key_valid), 32'd0);
      check_eq("mid_rst_any_key", 32'(any_key), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("mid_rst_row_hold", 32'(row_out), 32'(ROW_OFF));
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_row0", 32'(row_out), 32'(ROW0_ON));
      frames(2);
      check_eq("post_rst_2samples", 32'(matrix), 32'd0);
      check_eq("post_rst_no_ev", 32'(key_valid), 32'd0);
      frames(1);
      check_eq("post_rst_matrix", 32'(matrix), 32'h0085);
      expect_ev("post_rst_a", 0, 1'b1);
      expect_ev("post_rst_b", 2, 1'b1);
      expect_ev("post_rst_c", 7, 1'b1);
      check_eq("post_rst_empty", 32'(key_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
